// File: rtl/ser_demux_pkg.sv
// ============================================================================
// Module   : ser_demux_pkg
// Purpose  : Shared state encoding and helpers for the serial frame demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_demux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PORT = 3'd1,
        ST_LEN  = 3'd2,
        ST_TX   = 3'd3,
        ST_PAR  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_demux_shreg.sv
// ============================================================================
// Module   : ser_demux_shreg
// Purpose  : Generic MSB-first shift register with enable and clear; also
//            exposes the value it would take on the next shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_demux_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] r_q;

    generate
        if (WIDTH == 1) begin : g_w1
            assign q_next = din;
        end else begin : g_wn
            assign q_next = {r_q[WIDTH-2:0], din};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= q_next;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/ser_demux_gen.sv
// ============================================================================
// Module   : ser_demux_gen
// Purpose  : Serial frame demultiplexer: start bit, address, length, payload
//            routed to one of NUM_CH lanes. Optional trailing even-parity bit
//            when SER_DEMUX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_demux_gen
    import ser_demux_pkg::*;
#(
    parameter int PORT_W = 2,
    parameter int NUM_CH = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              ser_in,
    output logic [NUM_CH-1:0] ser_out,
    output logic [NUM_CH-1:0] ser_valid,
    output logic [PORT_W-1:0] port_q,
    output logic [LEN_W-1:0]  len_q,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int                c_cnt_w     = max_int(PORT_W, LEN_W);
    localparam logic [c_cnt_w-1:0] c_port_last = c_cnt_w'(PORT_W - 1);
    localparam logic [c_cnt_w-1:0] c_len_last  = c_cnt_w'(LEN_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [LEN_W-1:0]   c_dat_one   = LEN_W'(1);
    localparam logic [PORT_W:0]    c_num_ch    = (PORT_W + 1)'(NUM_CH);
`ifdef SER_DEMUX_PARITY_EN
    localparam state_t             c_after_tx  = ST_PAR;
`else
    localparam state_t             c_after_tx  = ST_DONE;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [LEN_W-1:0]   r_dat_cnt;
    logic               r_err;

    logic [PORT_W-1:0]  w_port_next;
    logic [LEN_W-1:0]   w_len_next;
    logic               w_port_en;
    logic               w_len_en;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_dat_load;
    logic               w_dat_dec;
    logic               w_frame_start;
    logic               w_addr_bad;
`ifdef SER_DEMUX_PARITY_EN
    logic               r_par;
    logic               w_par_bad;
`endif

    ser_demux_shreg #(.WIDTH(PORT_W)) u_port_sr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .en     (w_port_en),
        .din    (ser_in),
        .q      (port_q),
        .q_next (w_port_next)
    );

    ser_demux_shreg #(.WIDTH(LEN_W)) u_len_sr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .en     (w_len_en),
        .din    (ser_in),
        .q      (len_q),
        .q_next (w_len_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_port_en     = 1'b0;
        w_len_en      = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_dat_load    = 1'b0;
        w_dat_dec     = 1'b0;
        w_frame_start = 1'b0;
        w_addr_bad    = 1'b0;
`ifdef SER_DEMUX_PARITY_EN
        w_par_bad     = 1'b0;
`endif
        if (clk_en) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!ser_in) begin
                        w_state_next  = ST_PORT;
                        w_frame_start = 1'b1;
                        w_cnt_clr     = 1'b1;
                    end
                end
                ST_PORT: begin
                    w_port_en = 1'b1;
                    if (r_bit_cnt == c_port_last) begin
                        w_state_next = ST_LEN;
                        w_cnt_clr    = 1'b1;
                        // Judge the address as assembled including this bit
                        w_addr_bad   = ({1'b0, w_port_next} >= c_num_ch);
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                ST_LEN: begin
                    w_len_en = 1'b1;
                    if (r_bit_cnt == c_len_last) begin
                        w_dat_load = 1'b1;
                        w_cnt_clr  = 1'b1;
                        w_state_next = (w_len_next != '0) ? ST_TX : c_after_tx;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                ST_TX: begin
                    w_dat_dec = 1'b1;
                    if (r_dat_cnt == c_dat_one) begin
                        w_state_next = c_after_tx;
                    end
                end
`ifdef SER_DEMUX_PARITY_EN
                ST_PAR: begin
                    w_par_bad    = r_par ^ ser_in;
                    w_state_next = ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (!ser_in) begin
                        w_state_next  = ST_PORT;
                        w_frame_start = 1'b1;
                        w_cnt_clr     = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_dat_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_bit_cnt <= r_bit_cnt + c_cnt_one;
            end

            if (w_dat_load) begin
                r_dat_cnt <= w_len_next;
            end else if (w_dat_dec) begin
                r_dat_cnt <= r_dat_cnt - c_dat_one;
            end

            if (w_frame_start) begin
                r_err <= 1'b0;
`ifdef SER_DEMUX_PARITY_EN
            end else if (w_addr_bad || w_par_bad) begin
`else
            end else if (w_addr_bad) begin
`endif
                r_err <= 1'b1;
            end
        end
    end

`ifdef SER_DEMUX_PARITY_EN
    // Running XOR of address, length and payload bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_frame_start) begin
            r_par <= 1'b0;
        end else if (w_port_en || w_len_en || w_dat_dec) begin
            r_par <= r_par ^ ser_in;
        end
    end
`endif

    // An out-of-range address matches no lane, so it never asserts valid
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
            localparam logic [PORT_W-1:0] c_lane = PORT_W'(i);
            assign ser_valid[i] = (r_state == ST_TX) && (port_q == c_lane);
            assign ser_out[i]   = ser_valid[i] & ser_in;
        end
    endgenerate

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign frame_err = done & r_err;

endmodule

`default_nettype wire

// File: tb/tb_ser_demux_gen.sv
// ============================================================================
// Module   : tb_ser_demux_gen
// Purpose  : Directed self-checking bench for ser_demux_gen (4-lane and
//            3-lane instances share one serial line).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ser_demux_gen;

`ifdef SER_DEMUX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clk_en = 1'b1;
    logic       ser_in = 1'b1;

    logic [3:0] ser_out, ser_valid, len_q;
    logic [1:0] port_q;
    logic       busy, done, frame_err;
    logic [2:0] ser_out3, ser_valid3;
    logic [3:0] len_q3;
    logic [1:0] port_q3;
    logic       busy3, done3, frame_err3;

    ser_demux_gen dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .ser_in(ser_in),
        .ser_out(ser_out), .ser_valid(ser_valid), .port_q(port_q), .len_q(len_q),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    ser_demux_gen #(.PORT_W(2), .NUM_CH(3), .LEN_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .ser_in(ser_in),
        .ser_out(ser_out3), .ser_valid(ser_valid3), .port_q(port_q3), .len_q(len_q3),
        .busy(busy3), .done(done3), .frame_err(frame_err3)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int t;
    int cnt_done, cnt_err, cnt_done3, cnt_err3;

    logic [3:0] tr_valid [64];
    logic [3:0] tr_out   [64];
    logic       tr_done  [64];
    logic       tr_err   [64];
    logic       tr_busy  [64];
    logic [2:0] tr_valid3[64];
    logic       tr_done3 [64];
    logic       tr_err3  [64];

    logic [63:0] v, va, vb;
    int          n, na, nb;
    logic [3:0]  acc;
    logic [2:0]  acc3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bits MSB-first in v[n-1:0]; parity bit appended in the parity build
    task automatic build(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                         input logic bad_par, output logic [63:0] fv, output int fn);
        logic par;
        fv  = '0;
        fn  = 0;
        par = 1'b0;
        fv = {fv[62:0], 1'b0}; fn++;
        for (int i = 1; i >= 0; i--) begin fv = {fv[62:0], p[i]}; par ^= p[i]; fn++; end
        for (int i = 3; i >= 0; i--) begin fv = {fv[62:0], l[i]}; par ^= l[i]; fn++; end
        for (int i = int'(l) - 1; i >= 0; i--) begin fv = {fv[62:0], d[i]}; par ^= d[i]; fn++; end
        if (P == 1) begin fv = {fv[62:0], par ^ bad_par}; fn++; end
    endtask

    task automatic step(input logic b);
        ser_in = b;
        #2;
        if (t < 64) begin
            tr_valid[t]  = ser_valid;
            tr_out[t]    = ser_out;
            tr_done[t]   = done;
            tr_err[t]    = frame_err;
            tr_busy[t]   = busy;
            tr_valid3[t] = ser_valid3;
            tr_done3[t]  = done3;
            tr_err3[t]   = frame_err3;
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] fv, input int fn);
        for (int i = fn - 1; i >= 0; i--) step(fv[i]);
    endtask

    // One bit held over four clocks, enabled only on the last
    task automatic sstep(input logic b);
        ser_in = b;
        for (int k = 0; k < 4; k++) begin
            clk_en = (k == 3);
            #2;
            if (done)       cnt_done++;
            if (frame_err)  cnt_err++;
            if (done3)      cnt_done3++;
            if (frame_err3) cnt_err3++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ssend(input logic [63:0] fv, input int fn);
        cnt_done = 0; cnt_err = 0; cnt_done3 = 0; cnt_err3 = 0;
        for (int i = fn - 1; i >= 0; i--) sstep(fv[i]);
        sstep(1'b1);
        sstep(1'b1);
        clk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        t = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_valid", {28'd0, ser_valid}, 32'd0);
        chk("rst_port",  {30'd0, port_q}, 32'd0);
        chk("rst_len",   {28'd0, len_q}, 32'd0);
        rst_n = 1'b1;
        step(1'b1);
        step(1'b1);

        // Basic routing: addr 10, len 3, data 101
        t = 0;
        build(2'b10, 4'b0011, 15'b101, 1'b0, v, n);
        send(v, n); step(1'b1); step(1'b1);
        chk("t1_len_phase", {28'd0, tr_valid[6]}, 32'h0);
        chk("t1_valid0", {28'd0, tr_valid[7]}, 32'h4);
        chk("t1_valid1", {28'd0, tr_valid[8]}, 32'h4);
        chk("t1_valid2", {28'd0, tr_valid[9]}, 32'h4);
        chk("t1_out0",   {28'd0, tr_out[7]}, 32'h4);
        chk("t1_out1",   {28'd0, tr_out[8]}, 32'h0);
        chk("t1_out2",   {28'd0, tr_out[9]}, 32'h4);
        chk("t1_done",   {31'd0, tr_done[10+P]}, 32'd1);
        chk("t1_err",    {31'd0, tr_err[10+P]}, 32'd0);
        chk("t1_idle",   {31'd0, tr_busy[11+P]}, 32'd0);
        chk("t1_port",   {30'd0, port_q}, 32'd2);
        chk("t1_len",    {28'd0, len_q}, 32'd3);
        chk("t1_lane3ch", {29'd0, tr_valid3[7]}, 32'h4);

        // Zero length: addr 01
        t = 0;
        build(2'b01, 4'b0000, 15'd0, 1'b0, v, n);
        send(v, n); step(1'b1); step(1'b1);
        acc = '0;
        for (int i = 0; i < t; i++) acc |= tr_valid[i];
        chk("t2_novalid", {28'd0, acc}, 32'h0);
        chk("t2_pre_done", {31'd0, tr_done[6+P]}, 32'd0);
        chk("t2_done", {31'd0, tr_done[7+P]}, 32'd1);

        // Address 3: lane 3 on 4-ch, out of range on 3-ch
        t = 0;
        build(2'b11, 4'b0010, 15'b11, 1'b0, v, n);
        send(v, n); step(1'b1); step(1'b1);
        acc3 = '0;
        for (int i = 0; i < t; i++) acc3 |= tr_valid3[i];
        chk("t3_oor_novalid", {29'd0, acc3}, 32'h0);
        chk("t3_oor_done", {31'd0, tr_done3[9+P]}, 32'd1);
        chk("t3_oor_err",  {31'd0, tr_err3[9+P]}, 32'd1);
        chk("t3_lane3",    {28'd0, tr_valid[7]}, 32'h8);
        chk("t3_ok_err",   {31'd0, tr_err[9+P]}, 32'd0);

        // Back-to-back: second start bit lands in DONE
        t = 0;
        build(2'b00, 4'b0001, 15'b1, 1'b0, va, na);
        build(2'b01, 4'b0001, 15'b1, 1'b0, vb, nb);
        send(va, na); send(vb, nb); step(1'b1); step(1'b1);
        chk("t4_a_valid", {28'd0, tr_valid[7]}, 32'h1);
        chk("t4_a_out",   {28'd0, tr_out[7]}, 32'h1);
        chk("t4_a_done",  {31'd0, tr_done[8+P]}, 32'd1);
        chk("t4_no_idle", {31'd0, tr_busy[9+P]}, 32'd1);
        chk("t4_b_valid", {28'd0, tr_valid[15+P]}, 32'h2);
        chk("t4_b_out",   {28'd0, tr_out[15+P]}, 32'h2);
        chk("t4_b_done",  {31'd0, tr_done[16+2*P]}, 32'd1);

        // Asynchronous reset in the middle of TX
        t = 0;
        build(2'b11, 4'b0101, 15'b10110, 1'b0, v, n);
        for (int i = n - 1; i >= n - 9; i--) step(v[i]);
        ser_in = 1'b1;
        #2;
        chk("t5_pre_valid", {28'd0, ser_valid}, 32'h8);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {28'd0, ser_valid}, 32'h0);
        chk("t5_rst_out",   {28'd0, ser_out}, 32'h0);
        chk("t5_rst_busy",  {31'd0, busy}, 32'd0);
        chk("t5_rst_port",  {30'd0, port_q}, 32'd0);
        chk("t5_rst_len",   {28'd0, len_q}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1);
        t = 0;
        build(2'b01, 4'b0010, 15'b01, 1'b0, v, n);
        send(v, n); step(1'b1); step(1'b1);
        chk("t5_valid", {28'd0, tr_valid[7]}, 32'h2);
        chk("t5_out0",  {28'd0, tr_out[7]}, 32'h0);
        chk("t5_out1",  {28'd0, tr_out[8]}, 32'h2);
        chk("t5_done",  {31'd0, tr_done[9+P]}, 32'd1);

        // Sparse enable: DONE / frame_err span four clocks
        build(2'b11, 4'b0001, 15'b1, 1'b0, v, n);
        ssend(v, n);
        chk("t6_done_clks",  cnt_done, 32'd4);
        chk("t6_err_clks",   cnt_err, 32'd0);
        chk("t6_done3_clks", cnt_done3, 32'd4);
        chk("t6_err3_clks",  cnt_err3, 32'd4);
`ifdef SER_DEMUX_PARITY_EN
        build(2'b10, 4'b0001, 15'b1, 1'b1, v, n);
        ssend(v, n);
        chk("t6_badpar_err", cnt_err, 32'd4);
        build(2'b10, 4'b0001, 15'b1, 1'b0, v, n);
        ssend(v, n);
        chk("t6_goodpar_err", cnt_err, 32'd0);
        chk("t6_goodpar_done", cnt_done, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
